batrider_input_cond: RTL and testbench
======================================

# batrider_input_cond

Input conditioner placed directly upstream of `batrider_game`. It takes raw active-low cabinet inputs and delivers the conditioned `joystick1`, `joystick2`, `start_button`, `coin_input` and `service` signals. Each input is synchronised and debounced. Coin pulses get a guaranteed minimum width and spacing, with per-slot lockout and a one-cycle coin-counter event. Optional autofire can be applied to button 1.

## Interface
- `CLK_HZ`, 48000000, CLK frequency; sets the 1 ms tick prescaler.
- `DB_MS`, 4, debounce stability window, in ms ticks (1..15).
- `COIN_MS`, 100, coin output active width, in ms ticks.
- `COIN_GAP_MS`, 100, minimum inactive gap after a coin pulse, in ms ticks.
- `AF_MS`, 33, autofire half-period, in ms ticks.
- `CLK` input 1: system clock (48 MHz domain).
- `RESET_N` input 1: asynchronous reset, active-low.
- `JOY1_RAW`, `JOY2_RAW` input 10 each: raw joysticks, active-low; bit 4 is button 1.
- `START_RAW` input 4; `COIN_RAW` input 4; `SERVICE_RAW` input 1: raw, active-low.
- `COIN_LOCK` input 4: 1 = slot locked out (synchronous, level).
- `AUTOFIRE` input 2: per-player autofire enable for button 1.
- `JOY1`, `JOY2` output 10; `START` output 4; `COIN` output 4; `SERVICE` output 1: conditioned, active-low.
- `COIN_EVT` output 4: one-cycle pulse per accepted coin.

## Operation
- **Prescaler:** counter runs 0..CLK_HZ/1000-1. `tick` is high for one cycle on wrap.
- **Synchroniser and debounce:** applies to all 29 inputs.
  - Each bit passes through a 2-flop synchroniser.
  - Counter `cnt` is cleared whenever the sync value equals the debounced value.
  - Otherwise `cnt` increments on each `tick`. When it reaches DB_MS, the debounced value takes the sync value and `cnt` clears.
  - A glitch shorter than the window leaves the output unchanged.
- **Coin FSM:** one per slot, states IDLE, PULSE, GAP, with timer `ct`.
  - IDLE: a debounced coin falling edge with `COIN_LOCK`=0 moves to PULSE, loads `ct`=COIN_MS, drives `COIN`=0 and pulses `COIN_EVT`.
  - An edge while locked is discarded.
  - PULSE: `ct` decrements per tick. At `ct`=0 the FSM goes to GAP, drives `COIN`=1 and loads COIN_GAP_MS.
  - GAP: at `ct`=0 the FSM goes to IDLE.
  - An unlocked edge during PULSE or GAP sets a single `pend` flag; further edges are not counted.
  - On the cycle GAP reaches 0 with `pend` set, the FSM enters PULSE directly, clears `pend` and pulses `COIN_EVT`.
  - Asserting `COIN_LOCK` mid-PULSE or mid-GAP does not truncate the pulse, but it clears `pend`.
- **Pass-through:** all other debounced bits drive their outputs directly.

## Timing
- **Reset values:** all conditioned outputs 1, `COIN_EVT`=0, synchronisers 1, counters 0, FSMs IDLE, `pend`=0.
- **Debounce latency:** 2 cycles plus between DB_MS-1 and DB_MS ms, depending on tick phase.
- **COIN_EVT timing:** asserted in the same cycle as the IDLE→PULSE transition.
- **COIN timing:** `COIN` changes on the cycle after that transition, because outputs are registered.
- **Coin width:** `COIN` stays low for exactly COIN_MS ticks, measured from the first tick after entry.
- **Simultaneous events:** a coin edge on the same cycle as GAP→IDLE is treated as IDLE acceptance.
- **Reset mid-operation:** an asynchronous reset mid-pulse returns `COIN` to 1 immediately.

## Configuration
- **`BATRIDER_AUTOFIRE_EN` defined:**
  - When `AUTOFIRE[p]`=1 and debounced button 1 of player p is held (0), the output bit toggles every AF_MS ticks.
  - The output starts pressed (0) at the hold edge.
  - On release the output returns to 1 immediately.
- **`BATRIDER_AUTOFIRE_EN` undefined:** `AUTOFIRE` is ignored and button 1 is a plain pass-through. The port remains present.

## Structure
- **Package `batrider_input_pkg`:** coin state enum (IDLE/PULSE/GAP), `JOY_B1`=4, timer width derivation.
- **Sub-module `batrider_debounce`:** one bit wide, parameter DB_MS, takes `tick`. It is instantiated 29 times.
- The prescaler, coin FSMs and autofire logic stay in the top level.

## Test plan
All scenarios use CLK_HZ=48000, so one tick = 48 cycles.
- **Reset:** hold `RESET_N`=0 with random inputs → all outputs 1 and `COIN_EVT`=0. After release, with inputs held at 1, outputs stay 1.
- **Debounce:** `JOY1_RAW[0]` goes low for 2 ticks then high → `JOY1[0]` stays 1. Held low for 10 ticks → `JOY1[0]` falls within 4 ticks + 2 cycles.
- **Coin:** `COIN_RAW[0]` pulses low for 6 ticks → exactly one `COIN_EVT[0]`, then `COIN[0]` low for 100 ticks and high for at least 100 ticks.
- **Pending and lockout:**
  - A second coin during PULSE → a second `COIN_EVT` at the end of GAP; a third coin is dropped.
  - With `COIN_LOCK[1]`=1, a `COIN_RAW[1]` edge → no event.
- **Lock mid-pulse:** assert `COIN_LOCK[0]` during PULSE → pulse completes at full width and `pend` is cleared.
- **Autofire (macro defined):** `AUTOFIRE[0]`=1 with button 1 held for 200 ticks → `JOY1[4]` toggles every 33 ticks. On release → 1 the next cycle. With the macro undefined → steady 0 while held.

Source files
------------

// File: rtl/batrider_input_pkg.sv
// ---------------------------------------------------------------------------
// batrider_input_pkg
// Shared definitions for the Batrider cabinet input conditioner.
//   coin_state_t : per-slot coin FSM state (IDLE / PULSE / GAP)
//   JOY_B1       : joystick bit index carrying button 1
//   N_SLOTS      : number of coin slots
//   timer_w()    : width needed for a down/up counter holding max(a, b)
// ---------------------------------------------------------------------------
package batrider_input_pkg;

   typedef enum logic [1:0] {
      COIN_IDLE  = 2'd0,
      COIN_PULSE = 2'd1,
      COIN_GAP   = 2'd2
   } coin_state_t;

   localparam int JOY_B1  = 4;
   localparam int N_SLOTS = 4;

   function automatic int timer_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/batrider_debounce.sv
// ---------------------------------------------------------------------------
// batrider_debounce
// One-bit 2-flop synchroniser followed by a tick-based debouncer.
// The debounced value follows the synchronised value only after it has
// differed for DB_MS consecutive ms ticks; any return to the current
// debounced value restarts the count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : one-cycle 1 ms strobe
//   raw        : asynchronous raw input (idle high)
//   db         : debounced output (resets to 1)
// ---------------------------------------------------------------------------
module batrider_debounce #(
   parameter int DB_MS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic db
);

   logic [1:0] sync_q;
   logic [3:0] cnt;
   logic       s;

   assign s = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         cnt    <= '0;
         db     <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], raw};
         if (s == db) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == 4'(DB_MS - 1)) begin
               db  <= s;
               cnt <= '0;
            end else begin
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/batrider_input_cond.sv
// ---------------------------------------------------------------------------
// batrider_input_cond
// Conditions raw active-low cabinet inputs for batrider_game: every input is
// synchronised and debounced; coins are reshaped into fixed-width pulses with
// a minimum gap, per-slot lockout, one pending coin and a one-cycle event.
// Optional build macro: BATRIDER_AUTOFIRE_EN enables autofire on button 1.
// Ports:
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   JOY1_RAW, JOY2_RAW    : raw joysticks (bit 4 = button 1), active-low
//   START_RAW, COIN_RAW   : raw start buttons / coin switches, active-low
//   SERVICE_RAW           : raw service switch, active-low
//   COIN_LOCK             : per-slot lockout (1 = locked)
//   AUTOFIRE              : per-player autofire enable for button 1
//   JOY1, JOY2, START, COIN, SERVICE : conditioned outputs, active-low
//   COIN_EVT              : one-cycle pulse per accepted coin
//   COIN_STATE            : debug view of the four coin FSMs, 2 bits/slot
// ---------------------------------------------------------------------------
module batrider_input_cond
   import batrider_input_pkg::*;
#(
   parameter int CLK_HZ      = 48000000,
   parameter int DB_MS       = 4,
   parameter int COIN_MS     = 100,
   parameter int COIN_GAP_MS = 100,
   parameter int AF_MS       = 33
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [9:0] JOY1_RAW,
   input  logic [9:0] JOY2_RAW,
   input  logic [3:0] START_RAW,
   input  logic [3:0] COIN_RAW,
   input  logic       SERVICE_RAW,
   input  logic [3:0] COIN_LOCK,
   input  logic [1:0] AUTOFIRE,
   output logic [9:0] JOY1,
   output logic [9:0] JOY2,
   output logic [3:0] START,
   output logic [3:0] COIN,
   output logic       SERVICE,
   output logic [3:0] COIN_EVT,
   output logic [7:0] COIN_STATE
);

   localparam int PRESC = CLK_HZ / 1000;
   localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int CT_W  = timer_w(COIN_MS, COIN_GAP_MS);
   localparam int N_IN  = 29;

   // 1 ms prescaler
   logic [PW-1:0] pcnt;
   logic          tick;

   assign tick = (pcnt == PW'(PRESC - 1));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)  pcnt <= '0;
      else if (tick) pcnt <= '0;
      else           pcnt <= pcnt + PW'(1);
   end

   // Synchronise and debounce every input bit
   logic [N_IN-1:0] raw, db;
   logic [9:0]      joy1_db, joy2_db;
   logic [3:0]      start_db, coin_db;
   logic            service_db;

   assign raw = {SERVICE_RAW, COIN_RAW, START_RAW, JOY2_RAW, JOY1_RAW};

   for (genvar g = 0; g < N_IN; g++) begin : g_db
      batrider_debounce #(.DB_MS(DB_MS)) u_db (
         .clk   (CLK),
         .rst_n (RESET_N),
         .tick  (tick),
         .raw   (raw[g]),
         .db    (db[g])
      );
   end

   assign joy1_db    = db[9:0];
   assign joy2_db    = db[19:10];
   assign start_db   = db[23:20];
   assign coin_db    = db[27:24];
   assign service_db = db[28];

   // Coin FSMs. COIN is registered from the state, so it trails the
   // IDLE->PULSE transition (and COIN_EVT) by one cycle.
   coin_state_t         st [N_SLOTS];
   logic [CT_W-1:0]     ct [N_SLOTS];
   logic [N_SLOTS-1:0]  pend, evt_q, coin_q, coin_prev, fall, take;

   assign fall = coin_prev & ~coin_db;
   assign take = fall & ~COIN_LOCK;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            st[i] <= COIN_IDLE;
            ct[i] <= '0;
         end
         pend      <= '0;
         evt_q     <= '0;
         coin_q    <= '1;
         coin_prev <= '1;
      end else begin
         coin_prev <= coin_db;
         for (int i = 0; i < N_SLOTS; i++) begin
            evt_q[i]  <= 1'b0;
            coin_q[i] <= (st[i] != COIN_PULSE);
            case (st[i])
               COIN_IDLE: begin
                  if (take[i]) begin
                     st[i]    <= COIN_PULSE;
                     ct[i]    <= CT_W'(COIN_MS);
                     evt_q[i] <= 1'b1;
                  end
               end
               COIN_PULSE: begin
                  if (ct[i] == '0) begin
                     st[i] <= COIN_GAP;
                     ct[i] <= CT_W'(COIN_GAP_MS);
                  end else if (tick) begin
                     ct[i] <= ct[i] - CT_W'(1);
                  end
                  // Lock wins over a coincident edge: a locked slot never banks a coin.
                  if (COIN_LOCK[i])  pend[i] <= 1'b0;
                  else if (fall[i])  pend[i] <= 1'b1;
               end
               COIN_GAP: begin
                  if (ct[i] == '0) begin
                     // A fresh edge on the last gap cycle counts as an IDLE acceptance.
                     if ((pend[i] && !COIN_LOCK[i]) || take[i]) begin
                        st[i]    <= COIN_PULSE;
                        ct[i]    <= CT_W'(COIN_MS);
                        evt_q[i] <= 1'b1;
                     end else begin
                        st[i] <= COIN_IDLE;
                     end
                     pend[i] <= 1'b0;
                  end else begin
                     if (tick) ct[i] <= ct[i] - CT_W'(1);
                     if (COIN_LOCK[i])  pend[i] <= 1'b0;
                     else if (fall[i])  pend[i] <= 1'b1;
                  end
               end
               default: st[i] <= COIN_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      COIN_STATE = '0;
      for (int i = 0; i < N_SLOTS; i++) COIN_STATE[2*i +: 2] = st[i];
   end

   // Button 1 with optional autofire
   logic [1:0] b1_db, b1_out;

   assign b1_db = {joy2_db[JOY_B1], joy1_db[JOY_B1]};

`ifdef BATRIDER_AUTOFIRE_EN
   localparam int AF_W = timer_w(AF_MS, 1);
   logic [AF_W-1:0] af_cnt [2];
   logic [1:0]      af_lvl, held;

   assign held = AUTOFIRE & ~b1_db;

   // af_lvl rests at 0 while not held, so the output starts pressed at the hold edge.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         af_cnt[0] <= '0;
         af_cnt[1] <= '0;
         af_lvl    <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (!held[p]) begin
               af_lvl[p] <= 1'b0;
               af_cnt[p] <= '0;
            end else if (tick) begin
               if (af_cnt[p] == AF_W'(AF_MS - 1)) begin
                  af_lvl[p] <= ~af_lvl[p];
                  af_cnt[p] <= '0;
               end else begin
                  af_cnt[p] <= af_cnt[p] + AF_W'(1);
               end
            end
         end
      end
   end

   // Release is combinational from the debounced bit, so it is seen at once.
   assign b1_out = (held & af_lvl) | (~held & b1_db);
`else
   logic unused_autofire;
   assign unused_autofire = ^AUTOFIRE;
   assign b1_out          = b1_db;
`endif

   always_comb begin
      JOY1         = joy1_db;
      JOY1[JOY_B1] = b1_out[0];
      JOY2         = joy2_db;
      JOY2[JOY_B1] = b1_out[1];
   end

   assign START    = start_db;
   assign SERVICE  = service_db;
   assign COIN     = coin_q;
   assign COIN_EVT = evt_q;

endmodule

// File: tb/tb_batrider_input_cond.sv
// ---------------------------------------------------------------------------
// tb_batrider_input_cond
// Directed bench for batrider_input_cond at CLK_HZ=48000 (1 tick = 48 cycles).
// Inputs change just after a falling edge; outputs are sampled on falling
// edges. Expected cycle windows are derived from the tick arithmetic.
// ---------------------------------------------------------------------------
module tb_batrider_input_cond;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] joy1_raw, joy2_raw;
   logic [3:0] start_raw, coin_raw, coin_lock;
   logic       service_raw;
   logic [1:0] autofire;
   logic [9:0] joy1, joy2;
   logic [3:0] start, coin, coin_evt;
   logic       service;
   logic [7:0] coin_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   batrider_input_cond #(.CLK_HZ(48000)) dut (
      .CLK         (clk),
      .RESET_N     (rst_n),
      .JOY1_RAW    (joy1_raw),
      .JOY2_RAW    (joy2_raw),
      .START_RAW   (start_raw),
      .COIN_RAW    (coin_raw),
      .SERVICE_RAW (service_raw),
      .COIN_LOCK   (coin_lock),
      .AUTOFIRE    (autofire),
      .JOY1        (joy1),
      .JOY2        (joy2),
      .START       (start),
      .COIN        (coin),
      .SERVICE     (service),
      .COIN_EVT    (coin_evt),
      .COIN_STATE  (coin_state)
   );

   task automatic idle_inputs();
      joy1_raw    = '1;
      joy2_raw    = '1;
      start_raw   = '1;
      coin_raw    = '1;
      service_raw = 1'b1;
      coin_lock   = '0;
      autofire    = '0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         joy1_raw    = 10'($urandom_range(0, 1023));
         joy2_raw    = 10'($urandom_range(0, 1023));
         start_raw   = 4'($urandom_range(0, 15));
         coin_raw    = 4'($urandom_range(0, 15));
         service_raw = 1'($urandom_range(0, 1));
         coin_lock   = 4'($urandom_range(0, 15));
         autofire    = 2'($urandom_range(0, 3));
         wait_cycles(5);
      end
      checks++; if (joy1 !== 10'h3ff) begin errors++; $display("FAIL reset_joy1: got %h expected 3ff", joy1); end
      checks++; if (joy2 !== 10'h3ff) begin errors++; $display("FAIL reset_joy2: got %h expected 3ff", joy2); end
      checks++; if (start !== 4'hf) begin errors++; $display("FAIL reset_start: got %h expected f", start); end
      checks++; if (coin !== 4'hf) begin errors++; $display("FAIL reset_coin: got %h expected f", coin); end
      checks++; if (service !== 1'b1) begin errors++; $display("FAIL reset_service: got %b expected 1", service); end
      checks++; if (coin_evt !== 4'h0) begin errors++; $display("FAIL reset_evt: got %h expected 0", coin_evt); end
      checks++; if (coin_state !== 8'h00) begin errors++; $display("FAIL reset_state: got %h expected 00", coin_state); end
      idle_inputs();
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(300);
      checks++;
      if ({joy1, joy2, start, coin, service} !== 29'h1fff_ffff || coin_evt !== 4'h0) begin
         errors++;
         $display("FAIL post_reset_idle: got %h/%h expected 1fffffff/0", {joy1, joy2, start, coin, service}, coin_evt);
      end
   endtask

   task automatic test_passthrough();
      start_raw   = 4'b1010;
      service_raw = 1'b0;
      joy2_raw    = 10'h155;
      wait_cycles(300);
      checks++; if (start !== 4'b1010) begin errors++; $display("FAIL pass_start: got %b expected 1010", start); end
      checks++; if (service !== 1'b0) begin errors++; $display("FAIL pass_service: got %b expected 0", service); end
      checks++; if (joy2 !== 10'h155) begin errors++; $display("FAIL pass_joy2: got %h expected 155", joy2); end
      idle_inputs();
      wait_cycles(300);
      checks++;
      if (start !== 4'hf || service !== 1'b1 || joy2 !== 10'h3ff) begin
         errors++;
         $display("FAIL pass_release: got %h/%b/%h expected f/1/3ff", start, service, joy2);
      end
   endtask

   task automatic test_debounce();
      int low_seen = 0;
      int lat = -1;
      // 2-tick glitch: must not propagate
      joy1_raw[0] = 1'b0;
      for (int i = 0; i < 96 + 400; i++) begin
         if (i == 96) joy1_raw[0] = 1'b1;
         @(negedge clk);
         if (joy1[0] !== 1'b1) low_seen++;
      end
      checks++; if (low_seen != 0) begin errors++; $display("FAIL db_glitch: got %0d low cycles expected 0", low_seen); end
      // Sustained press: latency between 2+3 ticks+1 and 2+4 ticks cycles
      joy1_raw[0] = 1'b0;
      for (int n = 1; n <= 600; n++) begin
         @(negedge clk);
         if (joy1[0] === 1'b0) begin lat = n; break; end
      end
      checks++;
      if (lat < 147 || lat > 194) begin errors++; $display("FAIL db_press_latency: got %0d expected 147..194", lat); end
      checks++; if (joy1[9:1] !== 9'h1ff) begin errors++; $display("FAIL db_other_bits: got %h expected 1ff", joy1[9:1]); end
      wait_cycles(300);
      lat = -1;
      joy1_raw[0] = 1'b1;
      for (int n = 1; n <= 600; n++) begin
         @(negedge clk);
         if (joy1[0] === 1'b1) begin lat = n; break; end
      end
      checks++;
      if (lat < 147 || lat > 194) begin errors++; $display("FAIL db_release_latency: got %0d expected 147..194", lat); end
   endtask

   task automatic test_coin();
      int evt_n = 0, evt_at = -1, fall_at = -1, rise_at = -1, refall = 0;
      logic prev = 1'b1;
      for (int i = 0; i < 11000; i++) begin
         coin_raw[0] = (i < 288) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (coin_evt[0] === 1'b1) begin evt_n++; if (evt_at < 0) evt_at = i; end
         if (prev && !coin[0]) begin if (fall_at < 0) fall_at = i; else refall++; end
         if (!prev && coin[0] && rise_at < 0) rise_at = i;
         prev = coin[0];
      end
      checks++; if (evt_n != 1) begin errors++; $display("FAIL coin_evt_count: got %0d expected 1", evt_n); end
      checks++; if (fall_at != evt_at + 1) begin errors++; $display("FAIL coin_fall_after_evt: got %0d expected %0d", fall_at, evt_at + 1); end
      checks++;
      if (rise_at - fall_at < 4754 || rise_at - fall_at > 4801 || fall_at < 0) begin
         errors++; $display("FAIL coin_width: got %0d cycles expected 4754..4801", rise_at - fall_at);
      end
      checks++; if (refall != 0) begin errors++; $display("FAIL coin_gap: got %0d extra pulses expected 0", refall); end
      checks++;
      if (coin !== 4'hf || coin_state !== 8'h00) begin
         errors++; $display("FAIL coin_idle_after: got %h/%h expected f/00", coin, coin_state);
      end
   endtask

   task automatic test_pending();
      int evt_n = 0;
      int evt_t[$];
      int fall_t[$];
      int rise_t[$];
      logic prev = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         coin_raw[0] = ((i < 288) || (i >= 1500 && i < 1788) || (i >= 2500 && i < 2788)) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (coin_evt[0] === 1'b1) begin evt_n++; evt_t.push_back(i); end
         if (prev && !coin[0]) fall_t.push_back(i);
         if (!prev && coin[0]) rise_t.push_back(i);
         prev = coin[0];
      end
      checks++; if (evt_n != 2) begin errors++; $display("FAIL pend_evt_count: got %0d expected 2", evt_n); end
      if (evt_t.size() >= 2 && fall_t.size() >= 2 && rise_t.size() >= 2) begin
         checks++;
         if (evt_t[1] - evt_t[0] < 9554 || evt_t[1] - evt_t[0] > 9601) begin
            errors++; $display("FAIL pend_evt_spacing: got %0d expected 9554..9601", evt_t[1] - evt_t[0]);
         end
         checks++;
         if (fall_t[1] - rise_t[0] != 4800) begin
            errors++; $display("FAIL pend_gap_width: got %0d expected 4800", fall_t[1] - rise_t[0]);
         end
         checks++;
         if (rise_t[1] - fall_t[1] != 4800) begin
            errors++; $display("FAIL pend_second_width: got %0d expected 4800", rise_t[1] - fall_t[1]);
         end
      end else begin
         checks++; errors++;
         $display("FAIL pend_edges: got %0d evts %0d falls %0d rises expected 2 each", evt_t.size(), fall_t.size(), rise_t.size());
      end
   endtask

   task automatic test_lockout();
      int evt_n = 0, low_n = 0;
      coin_lock[1] = 1'b1;
      for (int i = 0; i < 600; i++) begin
         coin_raw[1] = (i < 288) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (coin_evt[1] === 1'b1) evt_n++;
         if (coin[1] !== 1'b1) low_n++;
      end
      coin_lock[1] = 1'b0;
      checks++; if (evt_n != 0) begin errors++; $display("FAIL lockout_evt: got %0d expected 0", evt_n); end
      checks++; if (low_n != 0) begin errors++; $display("FAIL lockout_coin: got %0d low cycles expected 0", low_n); end
   endtask

   task automatic test_lock_mid_pulse();
      int evt_n = 0, fall_at = -1, rise_at = -1;
      logic prev = 1'b1;
      for (int i = 0; i < 11000; i++) begin
         coin_raw[0]  = ((i < 288) || (i >= 1500 && i < 1788)) ? 1'b0 : 1'b1;
         coin_lock[0] = (i >= 2500 && i < 2600) ? 1'b1 : 1'b0;
         @(negedge clk);
         if (coin_evt[0] === 1'b1) evt_n++;
         if (prev && !coin[0] && fall_at < 0) fall_at = i;
         if (!prev && coin[0] && rise_at < 0) rise_at = i;
         prev = coin[0];
      end
      checks++; if (evt_n != 1) begin errors++; $display("FAIL lock_mid_evt: got %0d expected 1", evt_n); end
      checks++;
      if (fall_at < 0 || rise_at - fall_at < 4754 || rise_at - fall_at > 4801) begin
         errors++; $display("FAIL lock_mid_width: got %0d cycles expected 4754..4801", rise_at - fall_at);
      end
      checks++; if (coin_state !== 8'h00) begin errors++; $display("FAIL lock_mid_idle: got %h expected 00", coin_state); end
   endtask

   task automatic test_autofire();
      int chg[$];
      int high_n = 0;
      int bad_iv = 0;
      logic prev = 1'b1;
      autofire    = 2'b01;
      joy1_raw[4] = 1'b0;
      for (int i = 0; i < 9600; i++) begin
         @(negedge clk);
         if (joy1[4] !== prev) chg.push_back(i);
         prev = joy1[4];
      end
      checks++; if (chg.size() < 1) begin errors++; $display("FAIL af_press: got no press expected press"); end
`ifdef BATRIDER_AUTOFIRE_EN
      checks++; if (chg.size() < 6) begin errors++; $display("FAIL af_toggles: got %0d toggles expected >=5", chg.size() - 1); end
      if (chg.size() >= 2) begin
         checks++;
         if (chg[1] - chg[0] < 1537 || chg[1] - chg[0] > 1584) begin
            errors++; $display("FAIL af_first_period: got %0d expected 1537..1584", chg[1] - chg[0]);
         end
         for (int k = 2; k < chg.size(); k++) if (chg[k] - chg[k-1] != 1584) bad_iv++;
         checks++; if (bad_iv != 0) begin errors++; $display("FAIL af_period: got %0d bad intervals expected 0", bad_iv); end
      end
`else
      checks++; if (chg.size() != 1) begin errors++; $display("FAIL af_steady: got %0d changes expected 1", chg.size()); end
      checks++; if (joy1[4] !== 1'b0) begin errors++; $display("FAIL af_held_level: got %b expected 0", joy1[4]); end
`endif
      joy1_raw[4] = 1'b1;
      wait_cycles(200);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (joy1[4] === 1'b1) high_n++;
      end
      checks++; if (high_n != 2000) begin errors++; $display("FAIL af_release: got %0d high cycles expected 2000", high_n); end
      autofire = 2'b00;
   endtask

   task automatic test_reset_mid_pulse();
      int found = 0;
      coin_raw[2] = 1'b0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (coin[2] === 1'b0) begin found = 1; break; end
      end
      checks++; if (found != 1) begin errors++; $display("FAIL rst_mid_start: got no pulse expected pulse"); end
      wait_cycles(100);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (coin !== 4'hf || coin_evt !== 4'h0 || coin_state !== 8'h00) begin
         errors++; $display("FAIL rst_mid_pulse: got %h/%h/%h expected f/0/00", coin, coin_evt, coin_state);
      end
      idle_inputs();
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(10);
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_passthrough();
      test_debounce();
      test_coin();
      test_pending();
      test_lockout();
      test_lock_mid_pulse();
      test_autofire();
      test_reset_mid_pulse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
